// File: rtl/decode_pkg.sv
// Shared types and encodings for the Simple RISC Machine decode stage.
package decode_pkg;

   localparam logic [2:0] OPC_BRANCH = 3'b001;
   localparam logic [2:0] OPC_LDR    = 3'b011;
   localparam logic [2:0] OPC_STR    = 3'b100;
   localparam logic [2:0] OPC_ALU    = 3'b101;
   localparam logic [2:0] OPC_MOV    = 3'b110;
   localparam logic [2:0] OPC_HALT   = 3'b111;

   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_SH  = 2'b00;
   localparam logic [1:0] OP_MEM     = 2'b00;

   typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} dec_state_t;

   typedef enum logic [1:0] {SEL_RN, SEL_RM, SEL_RD} reg_sel_t;

   typedef struct packed {
      logic [1:0] n_reads;
      reg_sel_t   first_sel;
      reg_sel_t   second_sel;
      logic       wr_needed;
      reg_sel_t   wr_sel;
      logic       illegal;
   } dec_class_t;

   // Rn operands land in the A latch, everything else in B.
   function automatic logic sel_tag(input reg_sel_t sel);
      return (sel != SEL_RN);
   endfunction

endpackage

// File: rtl/decode_classify.sv
// Combinational opcode/op classifier; shared with the hazard unit.
// DECODE_ILLEGAL_TRAP_EN: flag unsupported encodings instead of decoding them as NOP.
module decode_classify
   import decode_pkg::*;
(
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output dec_class_t cls
);

`ifdef DECODE_ILLEGAL_TRAP_EN
   localparam logic TRAP = 1'b1;
`else
   localparam logic TRAP = 1'b0;
`endif

   // A one-read instruction always uses second_sel, since it reads only in RD1.
   always_comb begin
      cls.n_reads    = 2'd0;
      cls.first_sel  = SEL_RN;
      cls.second_sel = SEL_RN;
      cls.wr_needed  = 1'b0;
      cls.wr_sel     = SEL_RD;
      cls.illegal    = 1'b0;
      case (opcode)
         OPC_ALU: begin
            if (op == OP_MVN) begin
               cls.n_reads    = 2'd1;
               cls.second_sel = SEL_RM;
               cls.wr_needed  = 1'b1;
            end else begin
               cls.n_reads    = 2'd2;
               cls.second_sel = SEL_RM;
               cls.wr_needed  = (op != OP_CMP);
            end
         end
         OPC_MOV: begin
            if (op == OP_MOV_IMM) begin
               cls.wr_needed = 1'b1;
               cls.wr_sel    = SEL_RN;
            end else if (op == OP_MOV_SH) begin
               cls.n_reads    = 2'd1;
               cls.second_sel = SEL_RM;
               cls.wr_needed  = 1'b1;
            end else begin
               cls.illegal = TRAP;
            end
         end
         OPC_LDR: begin
            if (op == OP_MEM) begin
               cls.n_reads   = 2'd1;
               cls.wr_needed = 1'b1;
            end else begin
               cls.illegal = TRAP;
            end
         end
         OPC_STR: begin
            if (op == OP_MEM) begin
               cls.n_reads    = 2'd2;
               cls.second_sel = SEL_RD;
            end else begin
               cls.illegal = TRAP;
            end
         end
         OPC_BRANCH, OPC_HALT: ;
         default: cls.illegal = TRAP;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Handshaked decode stage: sequences register reads and holds decode fields for execute.
// DECODE_ILLEGAL_TRAP_EN: drives illegal=1 for unsupported encodings; otherwise illegal stays 0.
module decode_stage
   import decode_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int REG_IDX_W = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [15:0]          instruction,
   output logic                 rd_en,
   output logic [REG_IDX_W-1:0] readnum,
   output logic                 rd_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2:0]           opcode,
   output logic [1:0]           op,
   output logic [1:0]           alu_op,
   output logic [1:0]           shift,
   output logic [2:0]           cond,
   output logic [DATA_W-1:0]    sximm5,
   output logic [DATA_W-1:0]    sximm8,
   output logic [REG_IDX_W-1:0] writenum,
   output logic                 wr_needed,
   output logic                 illegal
);

   dec_state_t           state, nxt;
   dec_class_t           cls_in;
   logic                 acc;
   logic [REG_IDX_W-1:0] first_num, second_num, rd1_num_q;
   logic                 rd1_tag_q;

   function automatic logic [REG_IDX_W-1:0] sel_idx(input reg_sel_t sel, input logic [2:0] rn,
                                                      input logic [2:0] rm, input logic [2:0] rd);
      logic [REG_IDX_W-1:0] r;
      r = '0;
      case (sel)
         SEL_RN:  r[2:0] = rn;
         SEL_RM:  r[2:0] = rm;
         default: r[2:0] = rd;
      endcase
      return r;
   endfunction

   function automatic logic signed [DATA_W-1:0] sext5(input logic [4:0] f);
      return {{(DATA_W-5){f[4]}}, f};
   endfunction

   function automatic logic signed [DATA_W-1:0] sext8(input logic [7:0] f);
      return {{(DATA_W-8){f[7]}}, f};
   endfunction

   function automatic dec_state_t entry_state(input logic [1:0] n_reads);
      case (n_reads)
         2'd2:    return RD0;
         2'd1:    return RD1;
         default: return DONE;
      endcase
   endfunction

   decode_classify u_classify (
      .opcode (instruction[15:13]),
      .op     (instruction[12:11]),
      .cls    (cls_in)
   );

   assign in_ready   = (state == IDLE) | ((state == DONE) & out_ready);
   assign acc        = in_valid & in_ready;
   assign first_num  = sel_idx(cls_in.first_sel,  instruction[10:8], instruction[2:0], instruction[7:5]);
   assign second_num = sel_idx(cls_in.second_sel, instruction[10:8], instruction[2:0], instruction[7:5]);

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (acc) nxt = entry_state(cls_in.n_reads);
         RD0:     nxt = RD1;
         RD1:     nxt = DONE;
         DONE: begin
            if (acc)            nxt = entry_state(cls_in.n_reads);
            else if (out_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   // Read port and handshake strobes follow the next state, so they align with RD0/RD1/DONE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_en     <= 1'b0;
         out_valid <= 1'b0;
         readnum   <= '0;
         rd_tag    <= 1'b0;
         rd1_num_q <= '0;
         rd1_tag_q <= 1'b0;
         opcode    <= '0;
         op        <= '0;
         alu_op    <= '0;
         shift     <= '0;
         cond      <= '0;
         sximm5    <= '0;
         sximm8    <= '0;
         writenum  <= '0;
         wr_needed <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         rd_en     <= (nxt == RD0) | (nxt == RD1);
         out_valid <= (nxt == DONE);
         if (nxt == RD0) begin
            readnum <= first_num;
            rd_tag  <= sel_tag(cls_in.first_sel);
         end else if (nxt == RD1) begin
            readnum <= acc ? second_num : rd1_num_q;
            rd_tag  <= acc ? sel_tag(cls_in.second_sel) : rd1_tag_q;
         end
         if (acc) begin
            rd1_num_q <= second_num;
            rd1_tag_q <= sel_tag(cls_in.second_sel);
            opcode    <= instruction[15:13];
            op        <= instruction[12:11];
            alu_op    <= instruction[12:11];
            shift     <= instruction[4:3];
            cond      <= instruction[10:8];
            sximm5    <= sext5(instruction[4:0]);
            sximm8    <= sext8(instruction[7:0]);
            writenum  <= sel_idx(cls_in.wr_sel, instruction[10:8], instruction[2:0], instruction[7:5]);
            wr_needed <= cls_in.wr_needed;
            illegal   <= cls_in.illegal;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: random and directed instructions against a behavioural model.
module tb_decode_stage;

   localparam int DATA_W = 16;
   localparam int RW     = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              in_valid, in_ready, rd_en, rd_tag, out_valid, out_ready;
   logic [15:0]       instruction;
   logic [RW-1:0]     readnum, writenum;
   logic [2:0]        opcode, cond;
   logic [1:0]        op, alu_op, shift;
   logic [DATA_W-1:0] sximm5, sximm8;
   logic              wr_needed, illegal;

   decode_stage #(.DATA_W(DATA_W), .REG_IDX_W(RW)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .rd_en(rd_en), .readnum(readnum), .rd_tag(rd_tag),
      .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .op(op),
      .alu_op(alu_op), .shift(shift), .cond(cond), .sximm5(sximm5), .sximm8(sximm8),
      .writenum(writenum), .wr_needed(wr_needed), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]       instr;
      int                nreads;
      int                done;
      logic [RW-1:0]     wn;
      logic              wr;
      logic              ill;
      logic [DATA_W-1:0] s5;
      logic [DATA_W-1:0] s8;
   } item_t;

   item_t expq[$];
   int    rdq[$];
   int    n_vec  = 0;
   int    n_fail = 0;
   int    cyc    = 0;
   bit    mon_en = 0;

`ifdef DECODE_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: register usage per instruction class, as read/write lists.
   task automatic model_push(input logic [15:0] ins);
      item_t   it;
      int      reads[$];
      logic [4:0] key;
      longint  v;
      int      rn, rd, rm;
      key = ins[15:11];
      rn  = int'(ins[10:8]);
      rd  = int'(ins[7:5]);
      rm  = int'(ins[2:0]);
      it.instr = ins;
      it.wr    = 1'b0;
      it.wn    = ins[7:5];
      it.ill   = 1'b0;
      case (key)
         5'b10100, 5'b10110: begin reads = '{rn*2, rm*2+1}; it.wr = 1'b1; end
         5'b10101:           begin reads = '{rn*2, rm*2+1}; end
         5'b10111:           begin reads = '{rm*2+1}; it.wr = 1'b1; end
         5'b11010:           begin it.wr = 1'b1; it.wn = ins[10:8]; end
         5'b11000:           begin reads = '{rm*2+1}; it.wr = 1'b1; end
         5'b01100:           begin reads = '{rn*2}; it.wr = 1'b1; end
         5'b10000:           begin reads = '{rn*2, rd*2+1}; end
         default:            if (ins[15:13] != 3'b001 && ins[15:13] != 3'b111) it.ill = TRAP;
      endcase
      it.nreads = reads.size();
      it.done   = cyc + 1 + it.nreads;
      v = ins[4] ? longint'(ins[4:0]) - 32 : longint'(ins[4:0]);
      it.s5 = v[DATA_W-1:0];
      v = ins[7] ? longint'(ins[7:0]) - 256 : longint'(ins[7:0]);
      it.s8 = v[DATA_W-1:0];
      foreach (reads[i]) rdq.push_back(reads[i]);
      expq.push_back(it);
   endtask

   task automatic monitor_step();
      item_t h;
      bit    have, exp_ov;
      int    r;
      have = (expq.size() > 0);
      if (have) h = expq[0];
      exp_ov = have && (cyc >= h.done);
      chk("in_ready", in_ready, !have || (exp_ov && out_ready));
      chk("out_valid", out_valid, exp_ov);
      chk("rd_en", rd_en, have && (cyc < h.done) && (cyc >= h.done - h.nreads));
      if (rd_en) begin
         if (rdq.size() == 0) chk("rd_spurious", 1, 0);
         else begin
            r = rdq.pop_front();
            chk("readnum", readnum, r / 2);
            chk("rd_tag", rd_tag, r % 2);
         end
      end
      if (exp_ov) begin
         chk("opcode", opcode, h.instr[15:13]);
         chk("op", op, h.instr[12:11]);
         chk("alu_op", alu_op, h.instr[12:11]);
         chk("shift", shift, h.instr[4:3]);
         chk("cond", cond, h.instr[10:8]);
         chk("sximm5", sximm5, h.s5);
         chk("sximm8", sximm8, h.s8);
         chk("wr_needed", wr_needed, h.wr);
         if (h.wr) chk("writenum", writenum, h.wn);
         chk("illegal", illegal, h.ill);
         if (out_ready) void'(expq.pop_front());
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (mon_en) monitor_step();
   end

   task automatic drive(input logic v, input logic [15:0] ins, input logic ordy, output bit accepted);
      @(posedge clk);
      #1;
      in_valid    = v;
      instruction = ins;
      out_ready   = ordy;
      @(negedge clk);
      #2;
      accepted = in_valid && in_ready;
      if (accepted) model_push(ins);
   endtask

   task automatic send(input logic [15:0] ins);
      bit a = 0;
      for (int i = 0; i < 20 && !a; i++) drive(1'b1, ins, 1'b1, a);
      if (!a) chk("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      bit a;
      for (int i = 0; i < 20 && expq.size() > 0; i++) drive(1'b0, 16'h0, 1'b1, a);
      chk("drain", expq.size(), 0);
   endtask

   function automatic logic [15:0] gen();
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 9))
         0, 1:    r[15:13] = 3'b101;
         2:       r[15:11] = 5'b11010;
         3:       r[15:11] = 5'b11000;
         4:       r[15:11] = 5'b01100;
         5:       r[15:11] = 5'b10000;
         6:       r[15:13] = 3'b001;
         7:       r[15:13] = 3'b111;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      bit          a, hold;
      logic        v;
      logic [15:0] cur;
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      instruction = 16'h0;
      out_ready   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_readnum", readnum, 0);
      chk("rst_sximm8", sximm8, 0);
      chk("rst_writenum", writenum, 0);
      chk("rst_wr_needed", wr_needed, 0);
      chk("rst_illegal", illegal, 0);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      send(16'hA148); drain();
      send(16'hD3FF); drain();
      send(16'h859E); drain();
      send(16'h0000); drain();

      // Branch held by a stalled consumer, then a same-cycle handoff.
      a = 0;
      for (int i = 0; i < 20 && !a; i++) drive(1'b1, 16'h2105, 1'b0, a);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 16'hA148, 1'b0, a);
         chk("busy_hold", a, 0);
      end
      drive(1'b1, 16'hA148, 1'b1, a);
      chk("b2b_accept", a, 1);
      drain();

      hold = 0;
      v    = 0;
      cur  = 16'h0;
      for (int i = 0; i < 600; i++) begin
         if (!hold) begin
            v   = ($urandom_range(0, 3) != 0);
            cur = gen();
         end
         drive(v, cur, ($urandom_range(0, 2) != 0), a);
         hold = v && !a;
      end
      drain();

      // Abort a two-read sequence while it is in its second read.
      send(16'hA148);
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk); #2;
      mon_en = 1'b0;
      chk("abort_rd1_en", rd_en, 1);
      chk("abort_rd1_num", readnum, 0);
      reset_n = 1'b0;
      #1;
      chk("abort_rd_en", rd_en, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      expq.delete();
      rdq.delete();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_in_ready", in_ready, 1);
         chk("post_rst_out_valid", out_valid, 0);
         chk("post_rst_rd_en", rd_en, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode stage for the Simple RISC Machine datapath.
- Accepts one 16-bit instruction per transaction over a valid/ready interface.
- Sequences the register-file read port itself, one operand per cycle: Rn, then Rm or Rd.
- Presents held, sign-extended decode fields to the execute stage, replacing the externally driven nsel scheme.

Parameters:
- DATA_W, 16: width of the sximm5/sximm8 outputs; the sign bit is replicated up to DATA_W; legal values are 8 to 64.
- REG_IDX_W, 3: register index width; instruction fields stay at fixed bit positions; values above 3 zero-extend the index.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction available
- in_ready  out  1  stage can accept
- instruction  in  16  instruction word
- rd_en  out  1  register read strobe, one cycle per operand
- readnum  out  REG_IDX_W  register index for the current read
- rd_tag  out  1  read destination: 0 = A latch, 1 = B latch
- out_valid  out  1  decode fields valid
- out_ready  in  1  execute stage consumes
- opcode  out  3  instruction[15:13]
- op  out  2  instruction[12:11]
- alu_op  out  2  instruction[12:11]
- shift  out  2  instruction[4:3]
- cond  out  3  instruction[10:8]
- sximm5  out  DATA_W  sign-extended instruction[4:0]
- sximm8  out  DATA_W  sign-extended instruction[7:0]
- writenum  out  REG_IDX_W  destination register index
- wr_needed  out  1  instruction writes writenum
- illegal  out  1  unsupported opcode/op pair

Behaviour:
- FSM states: IDLE, RD0, RD1, DONE. Reset drives IDLE and clears every output register to 0; in_ready is 1 after reset.
- in_ready = (state==IDLE) | (state==DONE & out_ready), so back-to-back instructions are accepted.
- On accept, the instruction is latched and classified by opcode/op:
  - 101 ALU, op!=11: read Rn[10:8] tag A, then Rm[2:0] tag B; write Rd[7:5] except CMP (op 01).
  - 101 MVN (op 11): read Rm only, tag B; write Rd.
  - 110 op 10, MOV imm: no reads; write Rn[10:8].
  - 110 op 00, MOV shifted: read Rm tag B; write Rd.
  - 011 op 00, LDR: read Rn tag A; write Rd.
  - 100 op 00, STR: read Rn tag A, then Rd tag B; no write.
  - 001 branch, 111 HALT: no reads, no write.
  - Every other opcode/op pair is illegal.
- Two reads: RD0 (first), RD1 (second), then DONE. One read: RD1 only. Zero reads: straight to DONE.
- rd_en is asserted only in RD0/RD1; readnum and rd_tag are stable during rd_en and hold their last value otherwise.
- Latency: accept in cycle t; out_valid rises at t+1+reads, i.e. t+1, t+2 or t+3.
- out_valid stays high in DONE until out_ready. All decode fields are stable while out_valid=1 and change only on a new accept.
- out_ready with no new in_valid: return to IDLE, out_valid drops next cycle.
- out_ready and in_valid together: new accept, direct transition to RD0/RD1/DONE for the new instruction.
- in_valid while busy (RD0/RD1) is ignored; the source holds it.
- reset_n low mid-sequence aborts it immediately: rd_en=0 and out_valid=0 asynchronously.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined: illegal instructions perform no reads, wr_needed=0, and reach DONE with illegal=1.
- Undefined: the illegal port is tied to 0 and illegal encodings decode as NOP (no reads, no write).

Decomposition:
- Package decode_pkg holds:
  - opcode and op localparams (OPC_BRANCH, OPC_LDR, OPC_STR, OPC_ALU, OPC_MOV, OPC_HALT);
  - typedef enum dec_state_t;
  - typedef struct dec_class_t {n_reads, first_sel, second_sel, wr_needed, wr_sel, illegal}.
- Sub-module decode_classify: purely combinational instruction -> dec_class_t, reused by the future hazard unit.

Test Plan:
- 0xA148 (ADD R2,R1,R0,LSL#1) -> rd_en cycle1 readnum=1 tag0; cycle2 readnum=0 tag1; out_valid cycle3 writenum=2 shift=01 wr_needed=1.
- 0xD3FF (MOV R3,#-1) -> no rd_en; out_valid cycle1; sximm8=0xFFFF (DATA_W=16) or 0xFFFFFFFF (DATA_W=32); writenum=3.
- 0x859E (STR R4,[R5,#-2]) -> readnum=5 tag0, then 4 tag1; sximm5=0xFFFE; wr_needed=0.
- 0x2105 (BEQ) -> cond=001, sximm8=0x0005; out_valid cycle1; hold out_ready=0 for 5 cycles: fields stable, in_ready=0; then pulse out_ready with in_valid=1 carrying 0xA148 -> accepted same cycle.
- 0x0000 -> with DECODE_ILLEGAL_TRAP_EN: illegal=1, no rd_en; without: illegal=0, wr_needed=0.
- Drop reset_n during RD1 of 0xA148 -> rd_en=0 and out_valid=0 immediately, state IDLE, in_ready=1 after release.
